// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: digit width,
// FSM encoding and elaboration-time sizing helpers.
package bcd_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } bcd_state_t;

    // Bits needed to count 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Decimal digits needed to show the largest unsigned bin_w-bit value.
    function automatic int min_digits(input int bin_w);
        longint unsigned max_val;
        int n;
        max_val = (64'd1 << bin_w) - 64'd1;
        n = 1;
        while (max_val >= 64'd10) begin
            max_val = max_val / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_add3_cell.sv
// One BCD digit correction step of double dabble: digits of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
module bcd_add3_cell
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_DIGIT_W'(5)) begin
            digit_out = digit_in + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with optional signed input, leading-zero blanking and decimal overflow flag.
//
// state  | meaning
// IDLE   | waiting for start; outputs hold the last result
// SHIFT  | one add-3/shift step per cycle, BIN_W cycles in total
// FINISH | publish digits, blank, sign and overflow; done follows
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W    = 16,
    parameter int DIGITS   = 5,
    parameter int SIGNED   = 0,
    parameter int BLANK_LZ = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [BIN_W-1:0]              binary_in,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
    output logic [DIGITS-1:0]             blank,
    output logic                          negative,
    output logic                          overflow,
    output logic                          busy,
    output logic                          done
);

    localparam int DIG_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = clog2(BIN_W);
    // When the digit field can hold every input value no carry can leave it.
    localparam bit OVF_POSSIBLE = (DIGITS < min_digits(BIN_W));

    if (BIN_W < 2 || BIN_W > 32) begin : g_bad_bin_w
        $error("bin2bcd_seq: BIN_W=%0d outside 2..32", BIN_W);
    end
    if (DIGITS < 1 || DIGITS > 10) begin : g_bad_digits
        $error("bin2bcd_seq: DIGITS=%0d outside 1..10", DIGITS);
    end

    bcd_state_t         state_q;
    bcd_state_t         state_d;
    logic               load_en;
    logic               shift_en;
    logic               finish_en;
    logic               last_shift;

    logic [DIG_W-1:0]   dig_q;
    logic [DIG_W-1:0]   dig_adj;
    logic [BIN_W-1:0]   bin_q;
    logic [BIN_W-1:0]   mag;
    logic [CNT_W-1:0]   cnt_q;
    logic               in_neg;
    logic               neg_q;
    logic               ovf_q;
    logic [DIGITS-1:0]  blank_nxt;

    // Magnitude is taken at BIN_W bits, so the most negative code maps to 2^(BIN_W-1).
    always_comb begin
        in_neg = (SIGNED != 0) && binary_in[BIN_W-1];
        mag    = in_neg ? (~binary_in + BIN_W'(1)) : binary_in;
    end

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3_cell u_add3 (
            .digit_in  (dig_q[BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .digit_out (dig_adj[BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    assign last_shift = (cnt_q == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load_en   = 1'b0;
        shift_en  = 1'b0;
        finish_en = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load_en = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (last_shift) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                busy      = 1'b1;
                finish_en = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Blank flags scan down from the top digit; digit 0 always stays visible.
    always_comb begin
        logic upper_zero;
        blank_nxt  = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero   = upper_zero && (dig_q[BCD_DIGIT_W*i +: BCD_DIGIT_W] == '0);
            blank_nxt[i] = upper_zero;
        end
        if (BLANK_LZ == 0) begin
            blank_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dig_q    <= '0;
            bin_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            bcd_out  <= '0;
            blank    <= '0;
            negative <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= finish_en;
            if (load_en) begin
                dig_q <= '0;
                bin_q <= mag;
                cnt_q <= '0;
                neg_q <= in_neg;
                ovf_q <= 1'b0;
            end
            if (shift_en) begin
                dig_q <= {dig_adj[DIG_W-2:0], bin_q[BIN_W-1]};
                bin_q <= {bin_q[BIN_W-2:0], 1'b0};
                cnt_q <= cnt_q + CNT_W'(1);
                if (OVF_POSSIBLE && dig_adj[DIG_W-1]) begin
                    ovf_q <= 1'b1;
                end
            end
            if (finish_en) begin
                bcd_out  <= dig_q;
                blank    <= blank_nxt;
                negative <= neg_q;
                overflow <= ovf_q;
            end
        end
    end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
Parametrised sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock. It is the generalised successor to the fixed 16-bit/5-digit converter that feeds the seven-segment display path. It adds:
- configurable input width and digit count
- optional signed (two's-complement) input with a sign flag
- leading-zero blanking flags
- a decimal overflow flag
- a single-cycle done pulse

Parameters:
BIN_W, 16, width of binary_in; legal range 2..32.
DIGITS, 5, number of BCD digits produced; legal range 1..10.
SIGNED, 0, 1 = binary_in is two's complement; convert magnitude, report sign.
BLANK_LZ, 1, 1 = generate leading-zero blank flags; 0 = blank forced to all zeros.

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request conversion; sampled only in IDLE
binary_in  in  BIN_W  value to convert; captured on the accepting edge only
bcd_out  out  4*DIGITS  digit i at bits [4i+3:4i]; digit 0 is least significant
blank  out  DIGITS  blank[i]=1 means digit i is a leading zero
negative  out  1  input was negative (always 0 when SIGNED=0)
overflow  out  1  magnitude >= 10^DIGITS; bcd_out holds magnitude mod 10^DIGITS
busy  out  1  high while a conversion is in progress
done  out  1  one-cycle pulse when results update

Behaviour:
- Reset (synchronous, active-high): on an edge with reset=1:
  - state goes to IDLE
  - bcd_out, blank, negative, overflow, busy, done all go to 0
  - shift register and bit counter go to 0
  - reset has priority over every other input, including mid-conversion; the aborted result is discarded.
- FSM states are IDLE, SHIFT and FINISH.
- IDLE:
  - busy=0.
  - If start=1 at an edge: load the magnitude into the low BIN_W bits of the scratch register, clear the digit field, latch the sign and counter=0, then go to SHIFT.
  - SIGNED=1: magnitude = two's-complement absolute value, computed at BIN_W bits unsigned. -2^(BIN_W-1) converts to 2^(BIN_W-1) with negative=1.
  - SIGNED=0: magnitude = binary_in.
- SHIFT:
  - busy=1.
  - Each cycle, every digit >= 5 gets +3 (4-bit wrap), then the whole register shifts left by 1 and counter increments.
  - Bit 3 of the top digit is shifted out each cycle. If it is 1, set the internal sticky overflow flag.
  - After exactly BIN_W shift cycles, go to FINISH.
- FINISH:
  - busy=1, one cycle.
  - Register bcd_out, blank, negative and overflow from the scratch state.
  - Pulse done=1 in the cycle after this edge.
  - Go to IDLE.
- Latency: start accepted at edge k gives outputs valid and done=1 after edge k+BIN_W+1. busy is high from edge k to edge k+BIN_W+1.
- Start rules:
  - start while busy=1 (SHIFT or FINISH) is ignored and not queued.
  - start held high continuously produces back-to-back conversions; the next one is accepted in the IDLE cycle where done is high.
- Output hold: bcd_out, blank, negative and overflow hold their values until the next FINISH or reset. They do not change during a new conversion.
- Blanking (BLANK_LZ=1):
  - blank[i]=1 iff digit i and all higher digits are 0, for i >= 1.
  - blank[0] is always 0, so zero displays as "0".
  - blank is computed from the final digits, including the overflow case.
- Overflow: if overflow=1, the digits are still the exact value mod 10^DIGITS.
- negative never affects digits. Negative zero cannot occur.

Decomposition:
- Shared package bcd_pkg holds:
  - constant BCD_DIGIT_W=4
  - FSM state encoding (IDLE/SHIFT/FINISH)
  - function clog2 for sizing the counter
  - function that returns the minimum DIGITS for a given BIN_W, used for elaboration warnings
- One sub-module: bcd_add3_cell, a 4-bit combinational "if >= 5 add 3" cell, instantiated DIGITS times with generate.
- Blanking is a priority scan implemented inline.

Test Plan:
- Default params, binary_in=16'd65535, start pulse:
  - done exactly 17 cycles after the accepting edge
  - bcd_out=6,5,5,3,5 (digit4..0), blank=00000, overflow=0
- binary_in=0:
  - bcd_out=all 0, blank=5'b11110
  - binary_in=7 then gives blank=5'b11110 and digit0=7
- SIGNED=1, BIN_W=16, binary_in=-1234:
  - negative=1, digits 0,1,2,3,4, blank=5'b10000
  - binary_in=16'h8000 gives negative=1 and 32768
- DIGITS=4, binary_in=12345:
  - overflow=1, bcd_out=2,3,4,5, blank=0000
  - a following conversion of 9999 gives overflow=0
- start pulsed during SHIFT and during FINISH: ignored, exactly one done pulse, busy profile unchanged.
- reset asserted at cycle 8 of a conversion: all outputs 0 on the next cycle, no done pulse. A new start then converts 42 correctly.
